// File: rtl/uart_echo_fifo_pkg.sv
// Shared types and helpers for the UART loopback byte buffer.
package uart_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_echo_fifo_if.sv
// Receiver-to-buffer and buffer-to-transmitter signals of the loopback path.
// Handshake: one byte is offered per rising edge of rx_valid (rx_data valid while it is high);
// tx_flag is a one-cycle start pulse with tx_din stable, and tx_done is high while the transmitter is idle.
interface uart_echo_fifo_if #(
  parameter int DATA_W = uart_pkg::DATA_W_DEF
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_din;
  logic              tx_flag;
  logic              tx_done;

  modport master (output rx_data, rx_valid, tx_done, input tx_din, tx_flag);
  modport slave  (input rx_data, rx_valid, tx_done, output tx_din, tx_flag);
endinterface

// File: rtl/uart_echo_fifo_sync_fifo.sv
// Single-clock FIFO with a combinational head; occupancy counter drives full/empty.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   wr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   rd,
  output logic [DATA_W-1:0]      rdata,
  output logic [clog2(DEPTH):0]  count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Caller only writes when not full (or popping in the same cycle) and only reads when not empty.
  always_ff @(posedge sys_clk) begin
    if (wr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
endmodule

// File: rtl/uart_echo_fifo.sv
// Loopback byte buffer: captures each rx_valid rising edge into a FIFO and feeds the transmitter
// one byte per tx_flag/tx_done handshake, with sticky overflow and transmitter-timeout flags.
module uart_echo_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 16,
  parameter int ACK_TMO = 1024
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  uart_echo_fifo_if.slave       bus,
  input  logic                  clr_err,
  output logic [clog2(DEPTH):0] fifo_count,
  output logic                  overflow,
  output logic                  tx_err,
  output tx_state_t             state_dbg
);
  localparam int TW = clog2(ACK_TMO) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TMO - 1);

  tx_state_t         state;
  logic              rx_valid_d;
  logic              wr;
  logic              rd;
  logic              fifo_wr;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;
  logic [TW-1:0]     tmo;

  assign wr        = bus.rx_valid & ~rx_valid_d;
  assign rd        = (state == IDLE) & ~empty & bus.tx_done;
  // A same-cycle pop frees the slot, so a write into a full FIFO is still accepted then.
  assign fifo_wr   = wr & (~full | rd);
  assign state_dbg = state;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wr        (fifo_wr),
    .wdata     (bus.rx_data),
    .rd        (rd),
    .rdata     (head),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_valid_d <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rx_valid_d <= bus.rx_valid;
      if (clr_err)               overflow <= 1'b0;
      else if (wr & full & ~rd)  overflow <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      bus.tx_din  <= '0;
      bus.tx_flag <= 1'b0;
      tmo         <= '0;
      tx_err      <= 1'b0;
    end else begin
      bus.tx_flag <= 1'b0;
      if (clr_err) tx_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rd) begin
            bus.tx_din  <= head;
            bus.tx_flag <= 1'b1;
            tmo         <= '0;
            state       <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // A transmitter that never drops tx_done loses this byte; it is not retried.
          if (!bus.tx_done) begin
            state <= WAIT_DONE;
          end else if (tmo == TMO_LAST) begin
            if (!clr_err) tx_err <= 1'b1;
            state <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (bus.tx_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_echo_fifo.md
# uart_echo_fifo

Byte buffer between the UART `receive` stage and the UART `transmit` stage of the loopback path. It captures every received byte on the rising edge of the receiver's `valid` and stores it in a DEPTH-entry FIFO. It then drains the FIFO into the transmitter one byte at a time, using the transmitter's `tx_flag`/`done` handshake. Back-to-back received bytes are therefore never lost while the transmitter is busy, up to DEPTH bytes.

## Interface
- DATA_W, 8: byte width.
- DEPTH, 16: FIFO entries; power of two, at least 2.
- ACK_TMO, 1024: number of cycles to wait for `tx_done` to fall after a `tx_flag` pulse before declaring a transmitter error.
- sys_clk  in  1  system clock; all logic is on its rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- rx_data  in  DATA_W  received byte; valid while `rx_valid` is high.
- rx_valid  in  1  receiver valid level; may stay high for many cycles; one rising edge marks one byte.
- tx_din  out  DATA_W  byte presented to the transmitter.
- tx_flag  out  1  one-cycle start pulse to the transmitter.
- tx_done  in  1  transmitter idle when high; low while a frame is being sent.
- clr_err  in  1  synchronous clear of `overflow` and `tx_err`.
- fifo_count  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; a byte arrived while the FIFO was full.
- tx_err  out  1  sticky; an ACK_TMO timeout occurred.

## Operation
- Reset values: tx_din=0, tx_flag=0, fifo_count=0, overflow=0, tx_err=0, FSM in IDLE, pointers 0, rx_valid_d=0.
- Write path:
  - Register rx_valid into rx_valid_d.
  - `wr = rx_valid & ~rx_valid_d`; rx_data is written in the same cycle.
  - If `wr` and the FIFO is full: the byte is dropped, overflow<=1, pointers are unchanged.
- Read/transmit FSM:
  - IDLE: if fifo_count!=0 and tx_done=1, then tx_din<=head, rd_ptr++, tx_flag<=1, tmo<=0, go to WAIT_ACK.
  - WAIT_ACK: tx_flag<=0.
    - If tx_done=0, go to WAIT_DONE.
    - Else if tmo==ACK_TMO-1, tx_err<=1 and go to IDLE; the byte counts as consumed and is not retried.
    - Else tmo++.
  - WAIT_DONE: when tx_done=1, go to IDLE.
- tx_din holds its value until the next load.
- tx_flag is never high in two consecutive cycles.
- Simultaneous write and read in the same cycle: both pointers advance and fifo_count is unchanged. This applies even when the FIFO is full, because a read frees an entry in that cycle, so the write is accepted and overflow stays 0.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. fifo_count is a separate counter, and empty/full are derived from it.
- clr_err takes priority over a same-cycle set of the sticky flags: the flags stay set only if the condition recurs on a later cycle.
- Reset asserted mid-frame: everything returns to reset values immediately and the FIFO contents are discarded. The transmitter is reset by the same signal.

## Timing
- Empty FIFO, IDLE, tx_done=1, rx_valid first sampled high at edge N:
  - fifo_count=1 after edge N.
  - tx_flag=1 and tx_din=byte after edge N+1; tx_flag returns to 0 after edge N+2.
  - fifo_count returns to 0 after edge N+1.
- Minimum spacing between tx_flag pulses: 1 cycle in WAIT_ACK, 1 in WAIT_DONE and 1 in IDLE, so at least 3 cycles; in practice one UART frame.
- Byte ordering is strict FIFO.

## Structure
- Package `uart_pkg`: FSM state encoding (IDLE, WAIT_ACK, WAIT_DONE), a clog2 helper, and the default DATA_W.
- Sub-module `sync_fifo`:
  - Single-clock, DEPTH x DATA_W, inferred register or distributed RAM.
  - Ports: wr, wdata, rd, rdata (head, combinational), count, full, empty.
- FSM, edge detect and sticky flags live in the top-level `uart_echo_fifo`.

## Test plan
1. Single byte: rx_data=8'hA5, rx_valid held high for 10 cycles with tx_done=1 -> exactly one tx_flag pulse, two edges after the rise, with tx_din=8'hA5. fifo_count goes 0->1->0.
2. Burst: 5 bytes 8'h01..8'h05, each as a rising edge 2 cycles apart, while a transmitter model holds tx_done low 100 cycles per frame -> fifo_count peaks at 4 or 5. Bytes come out in order 01..05, overflow=0.
3. Overflow, DEPTH=16:
   - 17 bytes written with tx_done held low -> fifo_count=16, overflow=1, byte 17 is absent from the output.
   - clr_err then gives overflow=0.
4. Full with simultaneous read: FIFO full, and a write edge coincides with the IDLE pop -> fifo_count stays 16, overflow=0, the new byte is transmitted last.
5. Dead transmitter: after the pulse, tx_done stays 1 -> tx_err=1 exactly ACK_TMO cycles after WAIT_ACK entry, FSM returns to IDLE, and the next byte gets its own pulse.
6. Reset mid-operation: sys_rst_n low in WAIT_DONE with 3 bytes queued -> all outputs are at reset values during reset. After release there is no tx_flag until a new rx_valid rising edge.
